// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back data cache with per-set LRU and a blocking miss FSM.
// Defining DCACHE_STATS_EN adds saturating hit/miss counters on hit_cnt_o / miss_cnt_o.
module dcache_2way_top #(
    parameter int SETS_LOG2 = 5,
    parameter int LINE_LOG2 = 5,
    parameter int ADDR_W    = 32,
    localparam int LINE_W   = 8 << LINE_LOG2,
    localparam int TAG_W    = ADDR_W - SETS_LOG2 - LINE_LOG2,
    localparam int SETS     = 1 << SETS_LOG2,
    localparam int WORDS    = 1 << (LINE_LOG2 - 2),
    localparam int WSEL_W   = LINE_LOG2 - 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]             valid_q [2];
    logic [SETS-1:0]             dirty_q [2];
    logic [SETS-1:0]             lru_q;      // way to evict next
    logic [TAG_W-1:0]            tag_mem  [2][SETS];
    logic [WORDS-1:0][31:0]      line_mem [2][SETS];

    logic [TAG_W-1:0]            miss_tag_q;
    logic [SETS_LOG2-1:0]        miss_idx_q;
    logic                        victim_q;

    logic [TAG_W-1:0]            req_tag;
    logic [SETS_LOG2-1:0]        req_idx;
    logic [WSEL_W-1:0]           req_wsel;
    logic                        request, is_store;
    logic                        hit0, hit1, hit, hit_way, victim_d, miss_start;
    logic                        unused_addr;

    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx     = p1_addr_i[LINE_LOG2 +: SETS_LOG2];
    assign req_wsel    = p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^p1_addr_i[1:0];
    assign request     = p1_MemRead_i | p1_MemWrite_i;
    assign is_store    = p1_MemWrite_i;

    assign hit0       = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign hit1       = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign hit        = (state_q == IDLE) && (hit0 || hit1);
    assign hit_way    = ~hit0;
    assign miss_start = (state_q == IDLE) && request && !hit;
    assign victim_d   = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign p1_stall_o = request & ~hit;
    assign p1_data_o  = (hit && !is_store) ? line_mem[hit_way][req_idx][req_wsel] : 32'h0;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE:        if (request && !hit) state_d = MISS;
            MISS:        state_d = (valid_q[victim_q][miss_idx_q] && dirty_q[victim_q][miss_idx_q])
                                   ? WRITEBACK : REFILL;
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[victim_q][miss_idx_q], miss_idx_q, {LINE_LOG2{1'b0}}};
                mem_data_o   = line_mem[victim_q][miss_idx_q];
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {LINE_LOG2{1'b0}}};
                if (mem_ack_i) state_d = REFILL_DONE;
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q <= state_d;
            if (hit) lru_q[req_idx] <= ~hit_way;
            if (hit && is_store) dirty_q[hit_way][req_idx] <= 1'b1;
            if (state_q == REFILL && mem_ack_i) begin
                valid_q[victim_q][miss_idx_q] <= 1'b1;
                dirty_q[victim_q][miss_idx_q] <= 1'b0;
            end
        end
    end

    // NOTE: tag/line storage and miss registers are not reset; valid bits guard their contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (hit && is_store) line_mem[hit_way][req_idx][req_wsel] <= p1_data_i;
            if (state_q == REFILL && mem_ack_i) begin
                line_mem[victim_q][miss_idx_q] <= mem_data_i;
                tag_mem[victim_q][miss_idx_q]  <= miss_tag_q;
            end
            if (miss_start) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
                victim_q   <= victim_d;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (request && hit && hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss_start && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// Scoreboard bench for dcache_2way_top: directed accesses push expected load data and
// expected memory transactions; independent monitors pop and compare.
module tb_dcache_2way_top;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;   // write: expected writeback data; read: refill data to supply
    } mem_op_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic         mem_ack_i = 1'b0;

    int           n_vec  = 0;
    int           n_fail = 0;
    bit           resp_hold = 1'b0;

    logic [31:0]  core_exp  [$];
    string        core_name [$];
    mem_op_t      mem_exp   [$];

    logic [255:0] line40, line440, line840, linec40, dirty40;

    dcache_2way_top dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_ack_i    (mem_ack_i)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [255:0] set_word(input logic [255:0] l, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    // Core-side monitor: every accepted access (request high, no stall) retires one entry.
    initial forever begin
        @(negedge clk_i);
        if (!rst_i && (p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
            if (core_exp.size() == 0) begin
                check("core_queue_empty", 256'(core_exp.size()), 256'(1));
            end else begin
                logic [31:0] d;
                string       n;
                d = core_exp.pop_front();
                n = core_name.pop_front();
                check(n, 256'(p1_data_o), 256'(d));
            end
        end
    end

    // Memory responder/monitor: acks after two enabled cycles and checks the request.
    initial begin
        int lat;
        lat = 0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                lat = 0;
            end else if (mem_enable_o && !resp_hold) begin
                lat++;
                if (lat >= 2) begin
                    lat = 0;
                    if (mem_exp.size() == 0) begin
                        check("mem_unexpected_req", 256'(mem_exp.size()), 256'(1));
                    end else begin
                        mem_op_t e;
                        e = mem_exp.pop_front();
                        check("mem_write", 256'(mem_write_o), 256'(e.wr));
                        check("mem_addr", 256'(mem_addr_o), 256'(e.addr));
                        if (e.wr) check("mem_wb_data", mem_data_o, e.line);
                        else      mem_data_i = e.line;
                    end
                    mem_ack_i = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic push_mem(input bit wr, input logic [31:0] addr, input logic [255:0] line);
        mem_op_t e;
        e.wr = wr; e.addr = addr; e.line = line;
        mem_exp.push_back(e);
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input bit exp_miss, input string name);
        int cyc;
        @(posedge clk_i); #1;
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemRead_i  = !wr;
        p1_MemWrite_i = wr;
        core_exp.push_back(exp_data);
        core_name.push_back(name);
        @(negedge clk_i);
        check({name, "_stall"}, 256'(p1_stall_o), 256'(exp_miss));
        cyc = 0;
        while (p1_stall_o && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        if (p1_stall_o) begin
            check({name, "_timeout"}, 256'(p1_stall_o), 256'(0));
            core_exp.delete();
            core_name.delete();
        end
        @(posedge clk_i); #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int cyc;
        line40  = make_line(32'h1111_1111);
        line440 = make_line(32'h4400_0000);
        line840 = make_line(32'h8800_0000);
        linec40 = make_line(32'hCC00_0000);
        dirty40 = set_word(line40, 1, 32'hDEAD_BEEF);

        // Reset with a load request pending
        p1_addr_i    = 32'h40;
        p1_MemRead_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 256'(p1_stall_o), 256'(1));
        check("rst_data", 256'(p1_data_o), 256'(0));
        check("rst_mem_en", 256'(mem_enable_o), 256'(0));
        check("rst_mem_wr", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        @(posedge clk_i); #1;
        rst_i        = 1'b0;
        p1_MemRead_i = 1'b0;

        // Cold miss, store hit, load-back
        push_mem(1'b0, 32'h40, line40);
        access(1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b1, "ld40_miss");
        access(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 1'b0, "st44_hit");
        access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld44_hit");
        access(1'b0, 32'h48, 32'h0, 32'h1111_1113, 1'b0, "ld48_hit");
        access(1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b0, "ld40_hit");

        // Fill way 1, then evict dirty way 0 (LRU)
        push_mem(1'b0, 32'h440, line440);
        access(1'b0, 32'h440, 32'h0, 32'h4400_0000, 1'b1, "ld440_miss");
        push_mem(1'b1, 32'h40, dirty40);
        push_mem(1'b0, 32'h840, line840);
        access(1'b0, 32'h840, 32'h0, 32'h8800_0000, 1'b1, "ld840_evict");

        // Alternate hits; most recent is way 1, so the clean way 0 is replaced
        access(1'b0, 32'h440, 32'h0, 32'h4400_0000, 1'b0, "ld440_hit");
        access(1'b0, 32'h844, 32'h0, 32'h8800_0001, 1'b0, "ld844_hit");
        access(1'b0, 32'h448, 32'h0, 32'h4400_0002, 1'b0, "ld448_hit");
        push_mem(1'b0, 32'h40, dirty40);
        access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b1, "ld44_lru_miss");
        access(1'b0, 32'h45C, 32'h0, 32'h4400_0007, 1'b0, "ld45c_kept");

        // Store miss merges after refill, then its dirty line is written back
        push_mem(1'b0, 32'hC40, linec40);
        access(1'b1, 32'hC48, 32'h1234_5678, 32'h0, 1'b1, "stc48_miss");
        access(1'b0, 32'hC48, 32'h0, 32'h1234_5678, 1'b0, "ldc48_hit");
        access(1'b0, 32'hC4C, 32'h0, 32'hCC00_0003, 1'b0, "ldc4c_hit");
        access(1'b0, 32'h440, 32'h0, 32'h4400_0000, 1'b0, "ld440_hit2");
        push_mem(1'b1, 32'hC40, set_word(linec40, 2, 32'h1234_5678));
        push_mem(1'b0, 32'h840, line840);
        access(1'b0, 32'h840, 32'h0, 32'h8800_0000, 1'b1, "ld840_evict2");

        // Reset in the middle of a refill
        @(posedge clk_i); #1;
        resp_hold    = 1'b1;
        p1_addr_i    = 32'h0;
        p1_MemRead_i = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!mem_enable_o && cyc < 20);
        check("refill_enable", 256'(mem_enable_o), 256'(1));
        check("refill_write", 256'(mem_write_o), 256'(0));
        check("refill_addr", 256'(mem_addr_o), 256'(0));
        @(posedge clk_i); #1;
        rst_i        = 1'b1;
        p1_MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_mem_en", 256'(mem_enable_o), 256'(0));
        check("abort_stall", 256'(p1_stall_o), 256'(0));
        resp_hold = 1'b0;

        push_mem(1'b0, 32'h40, dirty40);
        access(1'b0, 32'h40, 32'h0, 32'h1111_1111, 1'b1, "ld40_after_rst");
        push_mem(1'b0, 32'h440, line440);
        access(1'b0, 32'h440, 32'h0, 32'h4400_0000, 1'b1, "ld440_after_rst");

        repeat (4) @(posedge clk_i);
        check("core_queue_drained", 256'(core_exp.size()), 256'(0));
        check("mem_queue_drained", 256'(mem_exp.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_2way_top.md
DCACHE_2WAY_TOP -- requirements
Module: dcache_2way_top

Interface
REQ-001 SHALL have parameter SETS_LOG2, default 5, log2 of number of sets (32 sets).
REQ-002 SHALL have parameter LINE_LOG2, default 5, log2 of line size in bytes; LINE_W = 8<<LINE_LOG2 (256 bits).
REQ-003 SHALL have parameter ADDR_W, default 32, address width; TAG_W = ADDR_W-SETS_LOG2-LINE_LOG2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  clock; all state changes on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
REQ-008 p1_data_i  in  32  store data.
REQ-009 p1_MemRead_i / p1_MemWrite_i  in  1 each  load / store request; both high = store.
REQ-010 p1_data_o  out  32  load data, valid when request high and p1_stall_o low.
REQ-011 p1_stall_o  out  1  high while request is outstanding and not hitting.
REQ-012 mem_addr_o  out  ADDR_W  line-aligned memory address (low LINE_LOG2 bits zero).
REQ-013 mem_data_o / mem_data_i  out / in  LINE_W  writeback line / refill line.
REQ-014 mem_enable_o / mem_write_o  out  1 each  memory request / write qualifier.
REQ-015 mem_ack_i  in  1  one-cycle memory completion pulse.

Function
REQ-016 Storage SHALL be 2-way set-associative, internal arrays: per way per set valid, dirty, tag, line; one LRU bit per set.
REQ-017 Address split: word select = addr[LINE_LOG2-1:2], index = addr[LINE_LOG2+SETS_LOG2-1:LINE_LOG2], tag = upper TAG_W bits.
REQ-018 Hit SHALL be combinational: valid and tag match in either way, in state IDLE only; p1_stall_o = request & ~hit.
REQ-019 Load hit: p1_data_o SHALL present the selected word same cycle; otherwise p1_data_o = 0.
REQ-020 Store hit: at the edge, selected word replaced, dirty set; other words unchanged.
REQ-021 Any hit SHALL set LRU of the set to point at the other way at the edge.
REQ-022 Victim: first invalid way (way 0 preferred), else way indicated by LRU; victim latched on entry to MISS.
REQ-023 States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE; encoding implementer's choice.
REQ-024 IDLE -> MISS when request & ~hit; MISS -> WRITEBACK if victim valid & dirty, else -> REFILL.
REQ-025 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line; on mem_ack_i -> REFILL.
REQ-026 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={request tag, index, 0}; on mem_ack_i, mem_data_i written to victim way, valid=1, dirty=0, tag updated -> REFILL_DONE.
REQ-027 REFILL_DONE -> IDLE after one cycle; the retried access then hits (store merges as store hit).
REQ-028 mem_enable_o SHALL deassert in the cycle after the final mem_ack_i; mem_ack_i outside WRITEBACK/REFILL ignored.
REQ-029 Request address/type SHALL be held by the core while stalled; a request dropped mid-miss still completes the refill.

Reset
REQ-030 rst_i SHALL clear all valid, dirty and LRU bits and force IDLE; tags/lines need not be cleared.
REQ-031 Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, p1_stall_o=request, p1_data_o=0.
REQ-032 Reset during WRITEBACK/REFILL SHALL abandon the transaction; mem_enable_o low next cycle, no array update.

Configuration
REQ-033 Macro DCACHE_STATS_EN: when defined, ports hit_cnt_o, miss_cnt_o (out, 32) exist; hit_cnt_o increments per cycle with request & hit, miss_cnt_o increments on IDLE->MISS; both saturate at 0xFFFFFFFF and clear on reset.
REQ-034 Without DCACHE_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-035 After reset, load 0x0000_0040 -> stall, MISS->REFILL, mem_addr_o=0x40, ack with line word0=0x1111_1111 -> p1_data_o=0x1111_1111, stall low in REFILL_DONE+1.
REQ-036 Store 0xDEAD_BEEF to 0x44 after REQ-035 -> no stall, word1 updated, dirty set; load 0x44 returns 0xDEAD_BEEF.
REQ-037 Loads 0x040, 0x440, 0x840 (same set) after dirtying 0x040 -> third miss evicts LRU way (0x040): WRITEBACK to 0x40 with dirty line, then REFILL 0x840.
REQ-038 Alternating hits to 0x040/0x440 then miss 0x840 -> victim is way not most recently hit.
REQ-039 rst_i pulsed during REFILL before ack -> IDLE, mem_enable_o=0 next cycle, subsequent load 0x40 misses.
REQ-040 With DCACHE_STATS_EN, 3 misses + 5 hits -> miss_cnt_o=3, hit_cnt_o=5.
